// File: rtl/ff_mode_bank.sv
// ============================================================================
// Module   : ff_mode_bank
// Brief    : WIDTH-bit register bank with run-time D/T/JK/SR next-state
//            selection, clock enable and SR-violation tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_mode_bank #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int               CNT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb,
  output logic             o_illegal,
  output logic             o_err_sticky,
  output logic [CNT_W-1:0] o_err_count
);

  localparam logic [1:0]       c_MODE_D  = 2'b00;
  localparam logic [1:0]       c_MODE_T  = 2'b01;
  localparam logic [1:0]       c_MODE_JK = 2'b10;
  localparam logic [1:0]       c_MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;
  logic             r_illegal;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_count;

  logic [WIDTH-1:0] w_q_next;
  logic             w_viol;

  // SR with a=b=1 resolves to hold, so illegal bits never disturb legal ones
  always_comb begin
    w_q_next = r_q;
    if (i_en) begin
      case (i_mode)
        c_MODE_D:  w_q_next = i_a;
        c_MODE_T:  w_q_next = r_q ^ i_a;
        c_MODE_JK: w_q_next = (i_a & ~r_q) | (~i_b & r_q);
        c_MODE_SR: w_q_next = (i_a & ~i_b) | (r_q & ~(i_a ^ i_b));
        default:   w_q_next = r_q;
      endcase
    end
  end

  assign w_viol = i_en && (i_mode == c_MODE_SR) && ((i_a & i_b) != '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q  <= INIT;
      r_qb <= ~INIT;
    end else begin
      r_q  <= w_q_next;
      r_qb <= ~w_q_next;
    end
  end

  // A violation on the same edge as a clear restarts the count at one
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_illegal    <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_illegal <= w_viol;
      if (w_viol) begin
        r_err_sticky <= 1'b1;
        if (i_clr_err) begin
          r_err_count <= c_CNT_ONE;
        end else if (r_err_count != c_CNT_MAX) begin
          r_err_count <= r_err_count + c_CNT_ONE;
        end
      end else if (i_clr_err) begin
        r_err_sticky <= 1'b0;
        r_err_count  <= '0;
      end
    end
  end

  assign o_q          = r_q;
  assign o_qb         = r_qb;
  assign o_illegal    = r_illegal;
  assign o_err_sticky = r_err_sticky;
  assign o_err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_ff_mode_bank.sv
// ============================================================================
// Module   : tb_ff_mode_bank
// Brief    : Directed self-checking bench for ff_mode_bank (WIDTH=8, INIT=A5).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ff_mode_bank;

  logic       r_clk;
  logic       r_rst;
  logic       r_en;
  logic [1:0] r_mode;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_clr;
  logic [7:0] w_q;
  logic [7:0] w_qb;
  logic       w_illegal;
  logic       w_sticky;
  logic [3:0] w_count;

  int n_vec;
  int n_err;

  ff_mode_bank #(
    .WIDTH(8),
    .INIT (8'hA5),
    .CNT_W(4)
  ) u_dut (
    .i_clock     (r_clk),
    .i_reset     (r_rst),
    .i_en        (r_en),
    .i_mode      (r_mode),
    .i_a         (r_a),
    .i_b         (r_b),
    .i_clr_err   (r_clr),
    .o_q         (w_q),
    .o_qb        (w_qb),
    .o_illegal   (w_illegal),
    .o_err_sticky(w_sticky),
    .o_err_count (w_count)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle 1 ns so sampling is away from the edge
  task automatic step();
    @(posedge r_clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
    r_en = en; r_mode = mode; r_a = a; r_b = b; r_clr = clr;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    r_rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    #12;
    chk("rst_q", w_q, 8'hA5);
    chk("rst_qb", w_qb, 8'h5A);
    chk("rst_illegal", w_illegal, 1'b0);
    chk("rst_sticky", w_sticky, 1'b0);
    chk("rst_count", w_count, 4'd0);
    r_rst = 1'b0;
    #1;
    chk("post_release_q", w_q, 8'hA5);

    // D mode and enable
    drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0);
    step();
    chk("d_q", w_q, 8'h3C);
    chk("d_qb", w_qb, 8'hC3);
    drive(1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en0_hold_q", w_q, 8'h3C);
    end
    drive(1'b0, 2'b11, 8'hFF, 8'hFF, 1'b0);
    step();
    chk("en0_sr_illegal", w_illegal, 1'b0);
    chk("en0_sr_count", w_count, 4'd0);
    chk("en0_sr_q", w_q, 8'h3C);

    // T then JK
    drive(1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    step();
    drive(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    step();
    chk("t_q", w_q, 8'hF0);
    chk("t_qb", w_qb, 8'h0F);
    drive(1'b1, 2'b10, 8'hC3, 8'h99, 1'b0);
    step();
    chk("jk_q", w_q, 8'h63);
    chk("jk_qb", w_qb, 8'h9C);

    // SR with one illegal bit alongside a legal set
    drive(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    step();
    drive(1'b1, 2'b11, 8'h81, 8'h01, 1'b0);
    step();
    chk("sr_q", w_q, 8'h80);
    chk("sr_illegal", w_illegal, 1'b1);
    chk("sr_sticky", w_sticky, 1'b1);
    chk("sr_count", w_count, 4'd1);
    drive(1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
    step();
    chk("sr_idle_illegal", w_illegal, 1'b0);
    chk("sr_idle_sticky", w_sticky, 1'b1);
    chk("sr_idle_count", w_count, 4'd1);
    drive(1'b1, 2'b11, 8'h02, 8'h80, 1'b0);
    step();
    chk("sr_set_clr_q", w_q, 8'h02);

    // Saturation: count starts at 1, 20 more violations pin it at 15
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_illegal", w_illegal, 1'b1);
      chk("sat_count", w_count, (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end
    chk("sat_q", w_q, 8'h02);
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    step();
    chk("clr_viol_count", w_count, 4'd1);
    chk("clr_viol_sticky", w_sticky, 1'b1);
    drive(1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
    step();
    chk("clr_count", w_count, 4'd0);
    chk("clr_sticky", w_sticky, 1'b0);
    chk("clr_illegal", w_illegal, 1'b0);
    chk("clr_q", w_q, 8'h02);

    // clr_err honoured while disabled
    drive(1'b1, 2'b11, 8'h10, 8'h10, 1'b0);
    step();
    chk("pre_en0clr_sticky", w_sticky, 1'b1);
    drive(1'b0, 2'b11, 8'h10, 8'h10, 1'b1);
    step();
    chk("en0clr_sticky", w_sticky, 1'b0);
    chk("en0clr_count", w_count, 4'd0);
    chk("en0clr_illegal", w_illegal, 1'b0);

    // Async reset in the middle of T-mode toggling
    drive(1'b1, 2'b11, 8'h40, 8'h40, 1'b0);
    step();
    drive(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    step();
    chk("tog_q", w_q, 8'hFD);
    #3;
    r_rst = 1'b1;
    #1;
    chk("async_q", w_q, 8'hA5);
    chk("async_qb", w_qb, 8'h5A);
    chk("async_illegal", w_illegal, 1'b0);
    chk("async_sticky", w_sticky, 1'b0);
    chk("async_count", w_count, 4'd0);
    #2;
    r_rst = 1'b0;
    step();
    chk("resume_q", w_q, 8'h5A);
    chk("resume_qb", w_qb, 8'hA5);
    step();
    chk("resume2_q", w_q, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
